// File: rtl/dt_pkg.sv
// Shared types and constants for the ticket/coin dispense controller.
// Holds the FSM state encoding, coin denominations and hop_fire bit positions.
package dt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TKT_FIRE,
    TKT_WAIT,
    COIN_SEL,
    COIN_FIRE,
    COIN_WAIT,
    DONE,
    FAULT
  } state_t;

  localparam logic [7:0] COIN10 = 8'd10;
  localparam logic [7:0] COIN5  = 8'd5;
  localparam logic [7:0] COIN1  = 8'd1;

  localparam int HOP10 = 2;
  localparam int HOP5  = 1;
  localparam int HOP1  = 0;

  // Value in yuan of a one-hot hopper select; zero when nothing is selected.
  function automatic logic [7:0] coin_value(input logic [2:0] sel);
    if (sel[HOP10]) return COIN10;
    if (sel[HOP5])  return COIN5;
    if (sel[HOP1])  return COIN1;
    return 8'd0;
  endfunction

endpackage

// File: rtl/item_timer.sv
// Per-item acknowledge timeout plus retry bookkeeping, shared by ticket and coin waits.
// expired is combinational in the last wait cycle; retry_ok means another fire attempt is allowed.
module item_timer #(
  parameter int TIMEOUT = 16,
  parameter int RETRIES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic retry_clr,
  input  logic retry_inc,
  output logic expired,
  output logic retry_ok
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  logic [CW-1:0] cnt;
  logic [RW-1:0] retries;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      retries <= '0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (run && !expired)
        cnt <= cnt + 1'b1;
      if (retry_clr)
        retries <= '0;
      else if (retry_inc)
        retries <= retries + 1'b1;
    end
  end

  // TIMEOUT wait cycles elapse when the count reaches TIMEOUT on this cycle.
  assign expired  = run && (cnt == CW'(TIMEOUT - 1));
  assign retry_ok = (retries < RW'(RETRIES));

endmodule

// File: rtl/dispense_ctrl.sv
// Issues tickets then greedy change (10/5/1) one item per fire/ack handshake, with timeout and retry.
// Takes one request at a time (req_ready only in IDLE); unrecoverable dispense errors park in FAULT until rst.
module dispense_ctrl
  import dt_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int RETRIES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_ticket,
  input  logic [7:0] req_change,
  output logic       req_ready,
  output logic       tkt_fire,
  input  logic       tkt_ack,
  output logic [2:0] hop_fire,
  input  logic       hop_ack,
  input  logic [2:0] hop_empty,
  output logic       done,
  output logic       fault,
  output logic [1:0] tkt_left,
  output logic [7:0] chg_left
);

  state_t     state, nxt;
  logic [2:0] sel, pick;
  logic [7:0] coin_val;
  logic       ack_ok, expired, retry_ok;
  logic       tmr_clr, tmr_run, retry_clr, retry_inc;

  assign coin_val  = coin_value(sel);
  assign tmr_clr   = (state == TKT_FIRE) || (state == COIN_FIRE);
  assign tmr_run   = (state == TKT_WAIT) || (state == COIN_WAIT);
  assign ack_ok    = ((state == TKT_WAIT) && tkt_ack) || ((state == COIN_WAIT) && hop_ack);
  assign retry_clr = (state == IDLE) || ack_ok;
  assign retry_inc = expired && !ack_ok && retry_ok;

  item_timer #(
    .TIMEOUT (TIMEOUT),
    .RETRIES (RETRIES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .run       (tmr_run),
    .retry_clr (retry_clr),
    .retry_inc (retry_inc),
    .expired   (expired),
    .retry_ok  (retry_ok)
  );

  // Largest coin that fits the remaining change and whose hopper is not empty.
  always_comb begin
    pick = '0;
    if (chg_left >= COIN10 && !hop_empty[HOP10])
      pick[HOP10] = 1'b1;
    else if (chg_left >= COIN5 && !hop_empty[HOP5])
      pick[HOP5] = 1'b1;
    else if (chg_left >= COIN1 && !hop_empty[HOP1])
      pick[HOP1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    tkt_fire  = 1'b0;
    hop_fire  = 3'b000;
    done      = 1'b0;
    fault     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_ticket != 2'd0)
            nxt = TKT_FIRE;
          else if (req_change != 8'd0)
            nxt = COIN_SEL;
          else
            nxt = DONE;
        end
      end
      TKT_FIRE: begin
        tkt_fire = 1'b1;
        nxt      = TKT_WAIT;
      end
      TKT_WAIT: begin
        if (tkt_ack) begin
          if (tkt_left > 2'd1)
            nxt = TKT_FIRE;
          else if (chg_left != 8'd0)
            nxt = COIN_SEL;
          else
            nxt = DONE;
        end else if (expired) begin
          nxt = retry_ok ? TKT_FIRE : FAULT;
        end
      end
      COIN_SEL: nxt = (pick != 3'b000) ? COIN_FIRE : FAULT;
      COIN_FIRE: begin
        hop_fire = sel;
        nxt      = COIN_WAIT;
      end
      COIN_WAIT: begin
        if (hop_ack)
          nxt = (chg_left != coin_val) ? COIN_SEL : DONE;
        else if (expired)
          nxt = retry_ok ? COIN_FIRE : FAULT;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      FAULT: fault = 1'b1;
      default: nxt = IDLE;
    endcase
  end

  // Remaining counts only move on accept and on a sampled ack, so FAULT freezes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      tkt_left <= '0;
      chg_left <= '0;
      sel      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tkt_left <= req_ticket;
            chg_left <= req_change;
          end
        end
        TKT_WAIT:  if (tkt_ack) tkt_left <= tkt_left - 2'd1;
        COIN_SEL:  sel <= pick;
        COIN_WAIT: if (hop_ack) chg_left <= chg_left - coin_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_ctrl.sv
// Bench for dispense_ctrl: table vectors, hand-written reset/held-request sequence, randomized transactions
// checked against a transaction-level model (ticket list, greedy change, per-attempt ack plan).
module tb_dispense_ctrl;

  localparam int TIMEOUT = 16;
  localparam int RETRIES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_ticket;
  logic [7:0] req_change;
  logic       req_ready;
  logic       tkt_fire;
  logic       tkt_ack;
  logic [2:0] hop_fire;
  logic       hop_ack;
  logic [2:0] hop_empty;
  logic       done;
  logic       fault;
  logic [1:0] tkt_left;
  logic [7:0] chg_left;

  always #5 clk = ~clk;

  dispense_ctrl #(
    .TIMEOUT (TIMEOUT),
    .RETRIES (RETRIES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ticket (req_ticket),
    .req_change (req_change),
    .req_ready  (req_ready),
    .tkt_fire   (tkt_fire),
    .tkt_ack    (tkt_ack),
    .hop_fire   (hop_fire),
    .hop_ack    (hop_ack),
    .hop_empty  (hop_empty),
    .done       (done),
    .fault      (fault),
    .tkt_left   (tkt_left),
    .chg_left   (chg_left)
  );

  typedef struct {
    int         tk;
    int         ch;
    logic [2:0] emp;
    int         d;
    int         nt;
    int         n10;
    int         n5;
    int         n1;
    bit         flt;
    int         tl;
    int         cl;
  } vec_t;

  vec_t tbl[10];

  int checks = 0;
  int errors = 0;
  int plan[$];
  int default_delay;
  bit noise;
  int n_t, n10, n5, n1, lat;
  bit got_done, got_fault;
  int fcyc[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int plan_at(input int i);
    if (i < plan.size()) return plan[i];
    return default_delay;
  endfunction

  function automatic int greedy(input int c, input logic [2:0] e);
    if (c >= 10 && !e[2]) return 10;
    if (c >= 5 && !e[1]) return 5;
    if (c >= 1 && !e[0]) return 1;
    return -1;
  endfunction

  function automatic int fire_code(input logic t, input logic [2:0] h);
    if (t && h == 3'b000) return 0;
    if (!t) begin
      case (h)
        3'b100: return 10;
        3'b010: return 5;
        3'b001: return 1;
        default: return 99;
      endcase
    end
    return 99;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; tkt_ack = 1'b0; hop_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_ready"}, req_ready, 1);
    check({nm, "_tkt_fire"}, tkt_fire, 0);
    check({nm, "_hop_fire"}, hop_fire, 0);
    check({nm, "_done"}, done, 0);
    check({nm, "_fault"}, fault, 0);
    check({nm, "_tkt_left"}, tkt_left, 0);
    check({nm, "_chg_left"}, chg_left, 0);
  endtask

  // Drive one transaction, act as issuer/hoppers following the ack plan, compare with the model.
  task automatic run_txn(input int tk, input int ch, input logic [2:0] emp, input string nm);
    int  exp_q[$];
    int  tl, cl, p, item, tries, pend, aline, code, wcyc;
    bit  acked, exp_fault, fire, prev_fire, fin;

    tl = tk; cl = ch; exp_fault = 1'b0; p = 0;
    while (!exp_fault && (tl > 0 || cl > 0)) begin
      item = (tl > 0) ? 0 : greedy(cl, emp);
      if (item < 0) begin
        exp_fault = 1'b1;
      end else begin
        acked = 1'b0; tries = 0;
        while (!acked && tries <= RETRIES) begin
          exp_q.push_back(item);
          if (plan_at(p) != 0) acked = 1'b1;
          p++; tries++;
        end
        if (!acked) exp_fault = 1'b1;
        else if (item == 0) tl--;
        else cl -= item;
      end
    end

    n_t = 0; n10 = 0; n5 = 0; n1 = 0; lat = 0;
    got_done = 1'b0; got_fault = 1'b0; fcyc.delete();
    tkt_ack = 1'b0; hop_ack = 1'b0;
    wcyc = 0;
    while (req_ready !== 1'b1 && wcyc < 100) begin
      @(negedge clk);
      tkt_ack = 1'b0; hop_ack = 1'b0;
      wcyc++;
    end
    check({nm, "_ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_ticket = tk[1:0]; req_change = ch[7:0]; hop_empty = emp;

    pend = 0; aline = 0; prev_fire = 1'b0; fin = 1'b0; p = 0;
    for (int cyc = 1; cyc <= 5000 && !fin; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; tkt_ack = 1'b0; hop_ack = 1'b0;
      fire = tkt_fire | (|hop_fire);
      check({nm, "_onehot"}, ($countones({tkt_fire, hop_fire}) <= 1), 1);
      check({nm, "_b2b"}, (prev_fire && fire), 0);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (aline == 0) tkt_ack = 1'b1;
          else hop_ack = 1'b1;
        end
      end
      if (fire) begin
        code = fire_code(tkt_fire, hop_fire);
        check({nm, "_seq"}, code, (p < exp_q.size()) ? exp_q[p] : -1);
        case (code)
          0: n_t++;
          10: n10++;
          5: n5++;
          1: n1++;
          default: ;
        endcase
        fcyc.push_back(cyc);
        pend = plan_at(p);
        p++;
        aline = tkt_fire ? 0 : 1;
        if (noise && $urandom_range(0, 3) == 0) begin
          if (aline == 0) tkt_ack = 1'b1;
          else hop_ack = 1'b1;
        end
      end
      if (noise && $urandom_range(0, 3) == 0) begin
        if (aline == 0) hop_ack = 1'b1;
        else tkt_ack = 1'b1;
      end
      if (done === 1'b1) begin got_done = 1'b1; fin = 1'b1; lat = cyc; end
      if (fault === 1'b1) begin got_fault = 1'b1; fin = 1'b1; end
      prev_fire = fire;
    end

    check({nm, "_finished"}, fin, 1);
    check({nm, "_fault"}, got_fault, exp_fault);
    check({nm, "_done"}, got_done, !exp_fault);
    check({nm, "_nfires"}, p, exp_q.size());
    check({nm, "_tkt_left"}, tkt_left, tl);
    check({nm, "_chg_left"}, chg_left, cl);
    check({nm, "_ready_end"}, req_ready, 0);
  endtask

  initial begin
    int nf;
    rst = 1'b1; req_valid = 1'b0; req_ticket = '0; req_change = '0;
    tkt_ack = 1'b0; hop_ack = 1'b0; hop_empty = '0; noise = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    tbl[0] = '{2,  17, 3'b000, 3,  2, 1,  1, 2, 1'b0, 0, 0};
    tbl[1] = '{0,  23, 3'b100, 3,  0, 0,  4, 3, 1'b0, 0, 0};
    tbl[2] = '{1,   0, 3'b000, 0,  3, 0,  0, 0, 1'b1, 1, 0};
    tbl[3] = '{0,   0, 3'b000, 1,  0, 0,  0, 0, 1'b0, 0, 0};
    tbl[4] = '{0,   3, 3'b001, 1,  0, 0,  0, 0, 1'b1, 0, 3};
    tbl[5] = '{3, 255, 3'b000, 16, 3, 25, 1, 0, 1'b0, 0, 0};
    tbl[6] = '{0,   9, 3'b010, 2,  0, 0,  0, 9, 1'b0, 0, 0};
    tbl[7] = '{0,  14, 3'b110, 1,  0, 0,  0, 14, 1'b0, 0, 0};
    tbl[8] = '{2,  12, 3'b100, 5,  2, 0,  2, 2, 1'b0, 0, 0};
    tbl[9] = '{0,  12, 3'b011, 4,  0, 1,  0, 0, 1'b1, 0, 2};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      plan.delete();
      default_delay = tbl[i].d;
      run_txn(tbl[i].tk, tbl[i].ch, tbl[i].emp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_n_tkt", i), n_t, tbl[i].nt);
      check($sformatf("vec%0d_n_10", i), n10, tbl[i].n10);
      check($sformatf("vec%0d_n_5", i), n5, tbl[i].n5);
      check($sformatf("vec%0d_n_1", i), n1, tbl[i].n1);
      check($sformatf("vec%0d_tbl_fault", i), fault, tbl[i].flt);
      check($sformatf("vec%0d_tbl_tkt_left", i), tkt_left, tbl[i].tl);
      check($sformatf("vec%0d_tbl_chg_left", i), chg_left, tbl[i].cl);
      if (tbl[i].d == 0)
        for (int k = 1; k < fcyc.size(); k++)
          check($sformatf("vec%0d_retry_gap", i), fcyc[k] - fcyc[k-1], TIMEOUT + 1);
      if (tbl[i].tk == 0 && tbl[i].ch == 0)
        check($sformatf("vec%0d_done_latency", i), lat, 1);
    end

    // Held request during a busy transaction, then reset in COIN_WAIT.
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_ticket = 2'd0; req_change = 8'd5; hop_empty = 3'b000;
    @(negedge clk);
    check("held_busy_ready", req_ready, 0);
    check("held_chg_latched", chg_left, 5);
    @(negedge clk);
    check("held_fire1", hop_fire, 3'b010);
    @(negedge clk);
    hop_ack = 1'b1;
    @(negedge clk);
    hop_ack = 1'b0;
    check("held_done", done, 1);
    check("held_not_reloaded", chg_left, 0);
    @(negedge clk);
    check("held_idle_ready", req_ready, 1);
    @(negedge clk);
    check("held_accept", chg_left, 5);
    req_valid = 1'b0;
    @(negedge clk);
    check("held_fire2", hop_fire, 3'b010);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    nf = 0;
    repeat (20) begin
      @(negedge clk);
      if (tkt_fire || (|hop_fire)) nf++;
    end
    check("midrst_no_fire", nf, 0);
    check("midrst_ready", req_ready, 1);

    // Randomized transactions with spurious acks and occasional missed acks.
    noise = 1'b1;
    got_fault = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int         rtk, rch;
      logic [2:0] remp;
      if (got_fault) do_reset();
      plan.delete();
      for (int k = 0; k < 100; k++)
        plan.push_back(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT));
      default_delay = 1;
      rtk = $urandom_range(0, 3);
      rch = $urandom_range(0, 60);
      for (int b = 0; b < 3; b++) remp[b] = ($urandom_range(0, 3) == 0);
      run_txn(rtk, rch, remp, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
